// File: rtl/dram_arb_pkg.sv
// Shared types and default widths for the DRAM port arbiter slice.
package dram_arb_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_ARD} owner_t;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// DRAM macro bus: the arbiter is the master, the DRAM macro the slave.
interface dram_port_arbiter_if
    import dram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_we, input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, output mem_rdata);
endinterface

// File: rtl/ard_addr_counter.sv
// Arduino streaming address counter with start reload, advance and wrap pulse.
module ard_addr_counter
    import dram_arb_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] ARD_BASE = '0,
    parameter logic [ADDR_W-1:0] ARD_LAST = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic              suppress,
    output logic [ADDR_W-1:0] ard_addr,
    output logic              ard_wrap
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ard_addr <= ARD_BASE;
            ard_wrap <= 1'b0;
        end else begin
            ard_wrap <= 1'b0;
            if (start) begin
                ard_addr <= ARD_BASE;
            end else if (advance && !suppress) begin
                if (ard_addr == ARD_LAST) begin
                    ard_addr <= ARD_BASE;
                    ard_wrap <= 1'b1;
                end else begin
                    ard_addr <= ard_addr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM port between the CPU load/store path and the Arduino stream.
//   state | meaning
//   IDLE  | arbitrate; on grant register mem bus from winner
//   ISSUE | address/write presented to DRAM (mem_we high for writes)
//   WAIT  | MEM_LAT cycles; last edge captures mem_rdata for the owner
//   DONE  | owner's ack/valid pulse, Arduino counter already advanced
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int                ADDR_W     = ADDR_W_DEF,
    parameter int                DATA_W     = DATA_W_DEF,
    parameter int                MEM_LAT    = 1,
    parameter logic [ADDR_W-1:0] ARD_BASE   = '0,
    parameter logic [ADDR_W-1:0] ARD_LAST   = '1,
    parameter int                STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    output logic                cpu_ack,
    output logic [DATA_W-1:0]   cpu_rdata,
    input  logic                ard_req,
    input  logic                ard_we,
    input  logic [DATA_W-1:0]   ard_wdata,
    input  logic                ard_start,
    output logic [ADDR_W-1:0]   ard_addr,
    output logic                ard_valid,
    output logic [DATA_W-1:0]   ard_rdata,
    output logic                ard_wrap,
    output logic                ard_overrun,
    dram_port_arbiter_if.master mem
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t            state;
    owner_t            owner;
    logic [2:0]        wait_cnt;
    logic              ard_pend;
    logic              ard_we_q;
    logic [DATA_W-1:0] ard_wdata_q;
    logic [SW-1:0]     starve_cnt;
    logic              ard_sup;
    logic              grant_cpu;
    logic              grant_ard;
    logic              advance;

    always_comb begin
        grant_cpu = 1'b0;
        grant_ard = 1'b0;
        if (state == IDLE) begin
            if (ard_pend && starve_cnt == SW'(STARVE_MAX)) grant_ard = 1'b1;
            else if (cpu_req)                               grant_cpu = 1'b1;
            else if (ard_pend)                              grant_ard = 1'b1;
        end
    end

    assign advance = (state == WAIT) && (wait_cnt == 3'd0) && (owner == OWN_ARD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            owner         <= OWN_NONE;
            wait_cnt      <= 3'd0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_we    <= 1'b0;
            cpu_ack       <= 1'b0;
            cpu_rdata     <= '0;
            ard_valid     <= 1'b0;
            ard_rdata     <= '0;
            ard_sup       <= 1'b0;
        end else begin
            cpu_ack    <= 1'b0;
            ard_valid  <= 1'b0;
            mem.mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        mem.mem_addr  <= cpu_addr;
                        mem.mem_wdata <= cpu_wdata;
                        mem.mem_we    <= cpu_we;
                        owner         <= OWN_CPU;
                        ard_sup       <= 1'b0;
                        state         <= ISSUE;
                    end else if (grant_ard) begin
                        mem.mem_addr  <= ard_addr;
                        mem.mem_wdata <= ard_wdata_q;
                        mem.mem_we    <= ard_we_q;
                        owner         <= OWN_ARD;
                        ard_sup       <= ard_start;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= 3'(MEM_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        if (owner == OWN_CPU) begin
                            cpu_rdata <= mem.mem_rdata;
                            cpu_ack   <= 1'b1;
                        end else begin
                            ard_rdata <= mem.mem_rdata;
                            ard_valid <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                DONE: begin
                    owner <= OWN_NONE;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // a restart during an Arduino access keeps its result but not its increment
            if (ard_start && owner == OWN_ARD && state != IDLE) ard_sup <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ard_pend    <= 1'b0;
            ard_overrun <= 1'b0;
            ard_we_q    <= 1'b0;
            ard_wdata_q <= '0;
            starve_cnt  <= '0;
        end else begin
            if (ard_start) begin
                ard_pend    <= 1'b0;
                ard_overrun <= 1'b0;
            end else if (grant_ard) begin
                ard_pend <= 1'b0;
            end
            // a request landing on the grant edge does not lose the granted one
            if (ard_req) begin
                ard_pend    <= 1'b1;
                ard_we_q    <= ard_we;
                ard_wdata_q <= ard_wdata;
                if (ard_pend && !ard_start && !grant_ard) ard_overrun <= 1'b1;
            end
            if (!ard_pend || grant_ard)
                starve_cnt <= '0;
            else if (grant_cpu && starve_cnt != SW'(STARVE_MAX))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    ard_addr_counter #(
        .ADDR_W   (ADDR_W),
        .ARD_BASE (ARD_BASE),
        .ARD_LAST (ARD_LAST)
    ) u_ard_cnt (
        .clk      (clk),
        .rst      (rst),
        .start    (ard_start),
        .advance  (advance),
        .suppress (ard_sup),
        .ard_addr (ard_addr),
        .ard_wrap (ard_wrap)
    );

endmodule
